// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared encodings for the pipeline hazard controller: IF/ID and ID/EX
// control encodings, the multiply/divide timer state codes, the bundled
// control-output struct with its four canned values, and small helpers
// used by the hazard equations and the timer counter sizing.
package hazard_ctrl_pkg;

  localparam logic PC_WRITE_ON     = 1'b1;
  localparam logic PC_WRITE_OFF    = 1'b0;
  localparam logic IF_ID_WRITE_ON  = 1'b1;
  localparam logic IF_ID_WRITE_OFF = 1'b0;
  localparam logic IF_ID_FLUSH_ON  = 1'b1;
  localparam logic IF_ID_FLUSH_OFF = 1'b0;
  localparam logic ID_EX_FLUSH_ON  = 1'b1;
  localparam logic ID_EX_FLUSH_OFF = 1'b0;

  // Multiply/divide timer state codes
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Pipeline control outputs, kept together so each case is one assignment
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET    = '{PC_WRITE_OFF, IF_ID_WRITE_OFF, IF_ID_FLUSH_ON,  ID_EX_FLUSH_ON};
  localparam ctrl_t CTRL_STALL    = '{PC_WRITE_OFF, IF_ID_WRITE_OFF, IF_ID_FLUSH_OFF, ID_EX_FLUSH_ON};
  localparam ctrl_t CTRL_REDIRECT = '{PC_WRITE_ON,  IF_ID_WRITE_ON,  IF_ID_FLUSH_ON,  ID_EX_FLUSH_OFF};
  localparam ctrl_t CTRL_NORMAL   = '{PC_WRITE_ON,  IF_ID_WRITE_ON,  IF_ID_FLUSH_OFF, ID_EX_FLUSH_OFF};

  // True when a source operand that is actually read matches a load destination
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

  // Counter width for the timer; one busy cycle still needs a 1-bit register
  function automatic int timer_bits(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_timer.sv
// muldiv_timer
// Tracks the multi-cycle multiply/divide unit. A start in RUN enters BUSY
// for exactly MULDIV_CYCLES cycles, then returns to RUN.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high
//   start  in  a mult/div leaves ID this cycle (already qualified by !stall)
//   busy   out registered, high while the unit is BUSY
module muldiv_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int             CB       = timer_bits(MULDIV_CYCLES);
  localparam logic [CB-1:0]  CNT_LOAD = CB'(MULDIV_CYCLES - 1);
  localparam logic [CB-1:0]  CNT_ZERO = CB'(0);
  localparam logic [CB-1:0]  CNT_ONE  = CB'(1);

  md_state_t       state;
  logic [CB-1:0]   cnt;

  // Timer FSM: cnt holds the remaining BUSY cycles after the current one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= CNT_ZERO;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
          end else begin
            state <= RUN;
            cnt   <= CNT_ZERO;
            busy  <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == CNT_ZERO) begin
            // A queued mult/div is stalled this cycle, so it issues from RUN
            state <= RUN;
            cnt   <= CNT_ZERO;
            busy  <= 1'b0;
          end else begin
            state <= BUSY;
            cnt   <= cnt - CNT_ONE;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= CNT_ZERO;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the 5-stage MIPS core. Detects load-use
// hazards and HI/LO hazards against the multiply/divide unit (stall), and
// taken branches / jumps resolved in ID (redirect). Keeps a saturating
// count of stall cycles.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   id_rs, id_rt               source fields of the IF/ID instruction
//   id_uses_rs, id_uses_rt     which sources the IF/ID instruction reads
//   ex_mem_read, ex_rt         load in ID/EX and its destination
//   id_branch_taken, id_jump   control-flow redirect resolved in ID
//   id_muldiv_start            mult/multu/div/divu in ID
//   id_mfhilo                  mfhi/mflo in ID
//   pc_write, if_id_write      pipeline enables (combinational)
//   if_id_flush, id_ex_flush   IF/ID zeroing and ID/EX bubble (combinational)
//   muldiv_busy                multiply/divide in progress (registered)
//   stall_count                saturating stall-cycle counter (registered)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             id_muldiv_start,
  input  logic             id_mfhilo,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic  load_use;
  logic  hilo_hazard;
  logic  stall;
  logic  redirect;
  logic  md_start;
  ctrl_t ctrl;

  // Register 0 never carries a real dependency, so a load to $0 is ignored
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    (src_match(id_uses_rs, id_rs, ex_rt) ||
                     src_match(id_uses_rt, id_rt, ex_rt));

  // Both HI/LO readers and a second mult/div must wait for the running op
  assign hilo_hazard = muldiv_busy && (id_mfhilo || id_muldiv_start);
  assign stall       = load_use || hilo_hazard;

  // A stalled branch redirects only once the stall clears
  assign redirect    = (id_branch_taken || id_jump) && !stall;
  assign md_start    = id_muldiv_start && !stall;

  muldiv_timer #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .busy  (muldiv_busy)
  );

  // Output selection by priority: reset, stall, redirect, normal
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end else if (redirect) begin
      ctrl = CTRL_REDIRECT;
    end else begin
      ctrl = CTRL_NORMAL;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign if_id_write = ctrl.if_id_write;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

  // Saturating stall-cycle counter; holds at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule
